// File: rtl/uart_rx_os_if.sv
// Consumer-side bundle of uart_rx_os: received word, error flags and the
// valid/ready handshake. The receiver drives it through the master modport.
interface uart_rx_os_if #(
  parameter int DATA_W = 7
);
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (
    output rx_valid, rx_data, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_valid, rx_data, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling serial receiver: synchronised line, mid-bit sampling, optional
// parity, 1/2 stop bits, error flags and a valid/ready output with overrun.
module uart_rx_os #(
  parameter int START_SIG    = 0,
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         rstN,
  input  logic         clk,
  input  logic         s_in,
  uart_rx_os_if.master rx,
  output logic         busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic START_LVL = 1'(START_SIG);
  localparam logic IDLE_LVL  = ~START_LVL;
  localparam logic ODD       = 1'(PARITY_ODD);
  localparam logic PAR_ON    = (PARITY_EN != 0);
  localparam logic TWO_STOP  = (STOP_BITS == 2);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, PARITY, DATA, STOP} state_t;

  state_t            state;
  state_t            state_next;
  logic              sync1;
  logic              sync2;
  logic              s_prev;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic              stop_idx;
  logic [DATA_W-1:0] shift;
  logic              p;
  logic              fe_acc;
  logic              commit;
  logic              start_edge;
  logic              tick;
  logic              cnt_clr;
  logic              take_parity;
  logic              take_data;
  logic              take_stop;
  logic              last_stop;

  assign start_edge = (sync2 == START_LVL) && (s_prev == IDLE_LVL);
  assign tick       = (cnt == CNT_LAST);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    take_parity = 1'b0;
    take_data   = 1'b0;
    take_stop   = 1'b0;
    last_stop   = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          cnt_clr    = 1'b1;
          state_next = START;
        end
      end
      // A start bit gone by mid-bit is a glitch, not a frame.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_clr = 1'b1;
          if (sync2 != START_LVL) state_next = IDLE;
          else if (PAR_ON)        state_next = PARITY;
          else                    state_next = DATA;
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_clr     = 1'b1;
          take_parity = 1'b1;
          state_next  = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_clr   = 1'b1;
          take_data = 1'b1;
          if (bit_idx == DATA_LAST) state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_clr   = 1'b1;
          take_stop = 1'b1;
          if (!TWO_STOP || stop_idx) begin
            last_stop  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1    <= IDLE_LVL;
      sync2    <= IDLE_LVL;
      s_prev   <= IDLE_LVL;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      p        <= 1'b0;
      fe_acc   <= 1'b0;
      commit   <= 1'b0;
    end else begin
      sync1  <= s_in;
      sync2  <= sync1;
      s_prev <= sync2;
      cnt    <= (cnt_clr || state == IDLE) ? '0 : cnt + 1'b1;
      commit <= last_stop;
      // The commit cycle may also see the next start edge; fe_acc is read before it clears.
      if (state == IDLE && start_edge) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        fe_acc   <= 1'b0;
      end
      if (take_parity) p <= sync2;
      if (take_data) begin
        shift   <= {sync2, shift[DATA_W-1:1]};
        bit_idx <= (bit_idx == DATA_LAST) ? '0 : bit_idx + 1'b1;
      end
      if (take_stop) begin
        stop_idx <= ~stop_idx;
        if (sync2 == START_LVL) fe_acc <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx.rx_valid   <= 1'b0;
      rx.rx_data    <= '0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else if (commit) begin
      rx.rx_data    <= shift;
      rx.parity_err <= PAR_ON & ((^shift ^ p) != ODD);
      rx.frame_err  <= fe_acc;
      rx.rx_valid   <= 1'b1;
      if (rx.rx_valid && !rx.rx_ready) rx.overrun <= 1'b1;
    end else if (rx.rx_valid && rx.rx_ready) begin
      rx.rx_valid <= 1'b0;
    end
  end
endmodule
